// File: rtl/calc_cmd_sequencer.sv
// Key-press sequencer for the calculator core: buffers keypad codes in a small FIFO and
// issues them one at a time on calc_cmd, pacing on core READY with error/timeout handling.
module calc_cmd_sequencer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [3:0]  IDLE_CMD = 4'hD,
    parameter int unsigned MIN_GAP  = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       key_valid,
    input  logic [3:0]                 key_code,
    output logic                       key_ready,
    input  logic                       clear,
    input  logic [1:0]                 calc_status,
    output logic [3:0]                 calc_cmd,
    output logic                       busy,
    output logic                       err,
    output logic                       timeout,
    output logic [$clog2(DEPTH+1)-1:0] fill
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam int unsigned GW = $clog2(MIN_GAP + 2);
    localparam int unsigned WW = $clog2(TIMEOUT + 2);

    localparam logic [1:0] StatusErr   = 2'b00;
    localparam logic [1:0] StatusReady = 2'b10;

    typedef enum logic [2:0] {StIdle, StIssue, StGap, StWait, StError} state_t;

    state_t          state;
    logic [3:0]      mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [3:0]      cmd_hold;
    logic [GW-1:0]   gap_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            push;
    logic            pop;

    assign key_ready = (fill != FW'(DEPTH)) && (state != StError);
    assign push      = key_valid && key_ready;
    assign pop       = (state == StIdle) && (fill != '0) && (calc_status == StatusReady);

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= key_code;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= StIdle;
            wptr     <= '0;
            rptr     <= '0;
            fill     <= '0;
            cmd_hold <= IDLE_CMD;
            gap_cnt  <= '0;
            wait_cnt <= '0;
            calc_cmd <= IDLE_CMD;
            busy     <= 1'b0;
            err      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout  <= 1'b0;
            calc_cmd <= IDLE_CMD;
            if (state != StError && calc_status == StatusErr) begin
                // Core error wins over everything, including a push or a pending issue.
                state <= StError;
                wptr  <= '0;
                rptr  <= '0;
                fill  <= '0;
                busy  <= 1'b1;
                err   <= 1'b1;
            end else begin
                if (push) begin
                    wptr <= wptr + PW'(1);
                end
                if (pop) begin
                    rptr <= rptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   fill <= fill + FW'(1);
                    2'b01:   fill <= fill - FW'(1);
                    default: fill <= fill;
                endcase

                unique case (state)
                    StIdle: begin
                        if (pop) begin
                            cmd_hold <= mem[rptr];
                            gap_cnt  <= GW'(MIN_GAP);
                            state    <= StIssue;
                            busy     <= 1'b1;
                        end
                    end
                    StIssue: begin
                        // The ISSUE cycle counts toward the gap, so issues are MIN_GAP+2 apart.
                        calc_cmd <= cmd_hold;
                        gap_cnt  <= (gap_cnt == '0) ? '0 : gap_cnt - GW'(1);
                        state    <= StGap;
                    end
                    StGap: begin
                        gap_cnt <= (gap_cnt == '0) ? '0 : gap_cnt - GW'(1);
                        if (gap_cnt <= GW'(1)) begin
                            wait_cnt <= WW'(TIMEOUT);
                            state    <= StWait;
                        end
                    end
                    StWait: begin
                        if (calc_status == StatusReady) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else if (wait_cnt == '0) begin
                            timeout <= 1'b1;
                            state   <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt - WW'(1);
                        end
                    end
                    StError: begin
                        if (clear) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                            err   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Randomised bench for calc_cmd_sequencer: a cycle-level reference model predicts FIFO contents,
// issued commands and status flags; a negedge monitor checks the DUT against it.
module tb_calc_cmd_sequencer;

    localparam int         DEPTH    = 4;
    localparam logic [3:0] IDLE_CMD = 4'hD;
    localparam int         MIN_GAP  = 2;
    localparam int         TIMEOUT  = 8;
    // Cycles from the pop until waiting for READY begins (ISSUE plus gap).
    localparam int         FIXED_CYC = (MIN_GAP > 2) ? MIN_GAP : 2;

    localparam int M_IDLE  = 0;
    localparam int M_FIXED = 1;
    localparam int M_WAIT  = 2;
    localparam int M_ERR   = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       clear;
    logic [1:0] calc_status;
    logic [3:0] calc_cmd;
    logic       busy;
    logic       err;
    logic       timeout;
    logic [2:0] fill;

    calc_cmd_sequencer #(
        .DEPTH    (DEPTH),
        .IDLE_CMD (IDLE_CMD),
        .MIN_GAP  (MIN_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .clear       (clear),
        .calc_status (calc_status),
        .calc_cmd    (calc_cmd),
        .busy        (busy),
        .err         (err),
        .timeout     (timeout),
        .fill        (fill)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [3:0] mq[$];
    logic [3:0] exp_q[$];
    logic [3:0] pend;
    bit         live = 0;
    bit         m_push;
    bit         m_to = 0;
    int         mode = M_IDLE;
    int         fixed = 0;
    int         wleft = 0;

    always @(posedge clock) begin
        m_to = 0;
        if (!reset_n) begin
            live = 1;
            mq.delete();
            exp_q.delete();
            mode = M_IDLE;
        end else if (live) begin
            if (mode != M_ERR && calc_status == 2'b00) begin
                mq.delete();
                mode = M_ERR;
            end else begin
                m_push = key_valid && (mq.size() < DEPTH) && (mode != M_ERR);
                case (mode)
                    M_IDLE: begin
                        if (mq.size() > 0 && calc_status == 2'b10) begin
                            pend  = mq.pop_front();
                            mode  = M_FIXED;
                            fixed = FIXED_CYC;
                        end
                    end
                    M_FIXED: begin
                        if (fixed == FIXED_CYC) exp_q.push_back(pend);
                        fixed--;
                        if (fixed == 0) begin
                            mode  = M_WAIT;
                            wleft = TIMEOUT + 1;
                        end
                    end
                    M_WAIT: begin
                        if (calc_status == 2'b10) begin
                            mode = M_IDLE;
                        end else begin
                            wleft--;
                            if (wleft == 0) begin
                                m_to = 1;
                                mode = M_IDLE;
                            end
                        end
                    end
                    default: begin
                        if (clear) mode = M_IDLE;
                    end
                endcase
                if (m_push) mq.push_back(key_code);
            end
        end
    end

    int n_to = 0;
    int n_err = 0;
    int n_full = 0;
    int n_cmd = 0;

    always @(negedge clock) begin
        if (live) begin
            chk("fill", int'(fill), mq.size());
            chk("key_ready", int'(key_ready), int'(mq.size() < DEPTH && mode != M_ERR));
            chk("busy", int'(busy), int'(mode != M_IDLE));
            chk("err", int'(err), int'(mode == M_ERR));
            chk("timeout", int'(timeout), int'(m_to));
            if (exp_q.size() > 0) begin
                chk("cmd", int'(calc_cmd), int'(exp_q.pop_front()));
                n_cmd++;
            end else begin
                chk("cmd_idle", int'(calc_cmd), int'(IDLE_CMD));
            end
            if (timeout === 1'b1) n_to++;
            if (err === 1'b1) n_err++;
            if (fill == 3'(DEPTH)) n_full++;
        end
    end

    task automatic cyc(input bit kv, input logic [3:0] kc, input logic [1:0] st, input bit clr);
        key_valid   = kv;
        key_code    = kc;
        calc_status = st;
        clear       = clr;
        @(posedge clock);
        #1;
    endtask

    logic [3:0] burst [4];
    logic [1:0] rst_st;
    int         hold;

    initial begin
        burst[0] = 4'h1; burst[1] = 4'h2; burst[2] = 4'hA; burst[3] = 4'h3;
        reset_n = 1'b0;
        // Reset with a key offered: nothing may be captured.
        cyc(1, 4'h5, 2'b10, 0);
        cyc(1, 4'h5, 2'b10, 0);
        reset_n = 1'b1;

        // Single key while the core is ready.
        cyc(1, 4'h7, 2'b10, 0);
        repeat (10) cyc(0, 4'h0, 2'b10, 0);

        // Burst with the core acknowledging only periodically.
        for (int i = 0; i < 4; i++) cyc(1, burst[i], 2'b11, 0);
        for (int j = 0; j < 40; j++) cyc(0, 4'h0, (j % 5 == 4) ? 2'b10 : 2'b11, 0);

        // Fill to DEPTH, then offer a key on the pop cycle and again after.
        repeat (6) cyc(1, 4'h6, 2'b11, 0);
        cyc(1, 4'h9, 2'b10, 0);
        cyc(1, 4'h8, 2'b11, 0);
        repeat (30) cyc(0, 4'h0, 2'b10, 0);

        // Core error while waiting with two keys queued, then clear.
        cyc(1, 4'h4, 2'b10, 0);
        cyc(1, 4'h5, 2'b10, 0);
        cyc(1, 4'h6, 2'b11, 0);
        repeat (3) cyc(0, 4'h0, 2'b11, 0);
        cyc(0, 4'h0, 2'b00, 0);
        repeat (3) cyc(1, 4'h2, 2'b11, 0);
        cyc(0, 4'h0, 2'b11, 1);
        repeat (3) cyc(0, 4'h0, 2'b10, 0);

        // Response timeout.
        cyc(1, 4'h8, 2'b10, 0);
        cyc(0, 4'h0, 2'b10, 0);
        repeat (20) cyc(0, 4'h0, 2'b01, 0);

        // Illegal code is forwarded unchanged.
        cyc(1, 4'hD, 2'b10, 0);
        repeat (8) cyc(0, 4'h0, 2'b10, 0);

        hold   = 0;
        rst_st = 2'b10;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 99)) inside
                    [0:3]:   rst_st = 2'b00;
                    [4:44]:  rst_st = 2'b10;
                    [45:72]: rst_st = 2'b01;
                    default: rst_st = 2'b11;
                endcase
                hold = (rst_st == 2'b00) ? 1 : $urandom_range(1, 14);
            end
            hold--;
            reset_n = ($urandom_range(0, 599) != 0);
            cyc(($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), rst_st,
                ($urandom_range(0, 3) == 0));
        end
        reset_n = 1'b1;
        repeat (20) cyc(0, 4'h0, 2'b10, 0);

        chk("cov_timeout", int'(n_to > 0), 1);
        chk("cov_err", int'(n_err > 0), 1);
        chk("cov_full", int'(n_full > 0), 1);
        chk("cov_cmds", int'(n_cmd > 50), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
